// File: rtl/egg_run_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : egg_run_sequencer_if
//  Purpose  : Switch-bus, CPU-observation and display signals of the egg-drop
//             run controller, bundled for connection between the controller
//             (slave) and the environment that drives it (master).
//  Revision : 1.0  initial release
// ============================================================================
interface egg_run_sequencer_if;
   logic [15:0] in_data_i;
   logic        load_floors_i;
   logic        load_resist_i;
   logic        start_i;
   logic [31:0] cpu_pc_i;
   logic [31:0] attempt_count_i;
   logic [31:0] broken_count_i;
   logic        last_broken_i;
   logic [31:0] cost_f1_i;
   logic [31:0] cost_f2_i;
   logic        cpu_rst_o;
   logic [31:0] init_floors_o;
   logic [31:0] init_resistance_o;
   logic [31:0] disp_data_o;
   logic [1:0]  page_o;
   logic        busy_o;
   logic        done_o;
   logic        timeout_o;
   logic        last_broken_o;

   // Environment side: drives switches and CPU status, observes the controller
   modport master (
      output in_data_i, load_floors_i, load_resist_i, start_i,
      output cpu_pc_i, attempt_count_i, broken_count_i, last_broken_i,
      output cost_f1_i, cost_f2_i,
      input  cpu_rst_o, init_floors_o, init_resistance_o, disp_data_o,
      input  page_o, busy_o, done_o, timeout_o, last_broken_o
   );

   // Controller side
   modport slave (
      input  in_data_i, load_floors_i, load_resist_i, start_i,
      input  cpu_pc_i, attempt_count_i, broken_count_i, last_broken_i,
      input  cost_f1_i, cost_f2_i,
      output cpu_rst_o, init_floors_o, init_resistance_o, disp_data_o,
      output page_o, busy_o, done_o, timeout_o, last_broken_o
   );
endinterface
`default_nettype wire

// File: rtl/egg_run_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : egg_run_sequencer
//  Purpose  : Run controller for the egg-drop CPU experiment. Latches floor
//             and resistance parameters, sequences CPU reset and run, detects
//             halt via a stable PC, flags timeouts, snapshots the result
//             counters and pages them onto the seven-segment display word.
//  Revision : 1.0  initial release
// ============================================================================
module egg_run_sequencer #(
   parameter int RST_CYCLES  = 16,
   parameter int HALT_CYCLES = 64,
   parameter int MAX_CYCLES  = 1000000,
   parameter int PAGE_CYCLES = 50000000
) (
   input  wire logic           clk_i,
   input  wire logic           rst_i,
   egg_run_sequencer_if.slave  bus
);
   localparam int SW = (HALT_CYCLES > 1) ? $clog2(HALT_CYCLES) : 1;
   localparam int PW = (PAGE_CYCLES > 1) ? $clog2(PAGE_CYCLES) : 1;

   localparam logic [31:0]   c_RST_LAST  = 32'(RST_CYCLES - 1);
   localparam logic [31:0]   c_MAX_LAST  = 32'(MAX_CYCLES - 1);
   localparam logic [SW-1:0] c_HALT_LAST = SW'(HALT_CYCLES - 1);
   localparam logic [PW-1:0] c_PAGE_LAST = PW'(PAGE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_RESET_CPU = 3'd1,
      S_RUN       = 3'd2,
      S_DONE      = 3'd3,
      S_TIMEOUT   = 3'd4
   } state_t;

   state_t        r_state;
   logic          r_start;
   logic [31:0]   r_cnt;
   logic [SW-1:0] r_stable;
   logic [31:0]   r_pc_prev;
   logic [PW-1:0] r_page_tmr;
   logic [1:0]    r_page;
   logic [15:0]   r_floors;
   logic [15:0]   r_resist;
   logic [31:0]   r_snap_att;
   logic [31:0]   r_snap_brk;
   logic [31:0]   r_snap_f1;
   logic [31:0]   r_snap_f2;
   logic          r_snap_lb;
   logic [31:0]   r_live;
   logic          r_cpu_rst;
   logic          r_busy;
   logic          r_done;
   logic          r_timeout;

   logic          w_start_ev;
   logic          w_accept;
   logic          w_pc_same;
   logic [31:0]   w_disp;
   logic [31:0]   w_page0;

   assign w_start_ev = bus.start_i & ~r_start;
   assign w_accept   = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_TIMEOUT);
   assign w_pc_same  = (bus.cpu_pc_i == r_pc_prev);
   assign w_page0    = {r_snap_att[15:0], r_snap_brk[15:0]};

   // Edge-detect history for start and a registered copy of the live counters
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_start <= 1'b0;
         r_live  <= 32'd0;
      end else begin
         r_start <= bus.start_i;
         r_live  <= {bus.attempt_count_i[15:0], bus.broken_count_i[15:0]};
      end
   end

   // Run parameters load only while no run is in progress; floors win a tie
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_floors <= 16'd0;
         r_resist <= 16'd0;
      end else if (w_accept) begin
         if (bus.load_floors_i)      r_floors <= bus.in_data_i;
         else if (bus.load_resist_i) r_resist <= bus.in_data_i;
      end
   end

   // Run sequencing FSM with registered status outputs and result snapshots
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_cnt      <= 32'd0;
         r_stable   <= '0;
         r_pc_prev  <= 32'd0;
         r_page_tmr <= '0;
         r_page     <= 2'd0;
         r_snap_att <= 32'd0;
         r_snap_brk <= 32'd0;
         r_snap_f1  <= 32'd0;
         r_snap_f2  <= 32'd0;
         r_snap_lb  <= 1'b0;
         r_cpu_rst  <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         if (w_accept && w_start_ev) begin
            r_state    <= S_RESET_CPU;
            r_cnt      <= 32'd0;
            r_page     <= 2'd0;
            r_page_tmr <= '0;
            r_cpu_rst  <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
         end else begin
            case (r_state)
               S_RESET_CPU: begin
                  r_cnt <= r_cnt + 32'd1;
                  if (r_cnt == c_RST_LAST) begin
                     r_state   <= S_RUN;
                     r_cnt     <= 32'd0;
                     r_stable  <= '0;
                     r_pc_prev <= bus.cpu_pc_i;
                     r_cpu_rst <= 1'b0;
                  end
               end
               S_RUN: begin
                  r_cnt <= r_cnt + 32'd1;
                  if (w_pc_same) begin
                     r_stable <= r_stable + SW'(1);
                  end else begin
                     r_stable  <= '0;
                     r_pc_prev <= bus.cpu_pc_i;
                  end
                  if ((w_pc_same && (r_stable == c_HALT_LAST)) || (r_cnt == c_MAX_LAST)) begin
                     r_snap_att <= bus.attempt_count_i;
                     r_snap_brk <= bus.broken_count_i;
                     r_snap_f1  <= bus.cost_f1_i;
                     r_snap_f2  <= bus.cost_f2_i;
                     r_snap_lb  <= bus.last_broken_i;
                     r_page     <= 2'd0;
                     r_page_tmr <= '0;
                     r_busy     <= 1'b0;
                     // Halt wins over timeout when both land on the same cycle
                     if (w_pc_same && (r_stable == c_HALT_LAST)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                     end else begin
                        r_state   <= S_TIMEOUT;
                        r_timeout <= 1'b1;
                        r_cpu_rst <= 1'b1;
                     end
                  end
               end
               S_DONE: begin
                  if (r_page_tmr == c_PAGE_LAST) begin
                     r_page_tmr <= '0;
                     r_page     <= r_page + 2'd1;
                  end else begin
                     r_page_tmr <= r_page_tmr + PW'(1);
                  end
               end
               S_IDLE, S_TIMEOUT: begin
               end
               default: begin
                  r_state   <= S_IDLE;
                  r_cpu_rst <= 1'b1;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b0;
                  r_timeout <= 1'b0;
               end
            endcase
         end
      end
   end

   // Display word selected purely from registered state and registered data
   always_comb begin
      w_disp = {r_floors, r_resist};
      case (r_state)
         S_RUN:     w_disp = r_live;
         S_TIMEOUT: w_disp = w_page0;
         S_DONE: begin
            case (r_page)
               2'd0:    w_disp = w_page0;
               2'd1:    w_disp = r_snap_f1;
               2'd2:    w_disp = r_snap_f2;
               default: w_disp = {r_floors, r_resist};
            endcase
         end
         default: w_disp = {r_floors, r_resist};
      endcase
   end

   assign bus.cpu_rst_o         = r_cpu_rst;
   assign bus.init_floors_o     = {16'd0, r_floors};
   assign bus.init_resistance_o = {16'd0, r_resist};
   assign bus.disp_data_o       = w_disp;
   assign bus.page_o            = r_page;
   assign bus.busy_o            = r_busy;
   assign bus.done_o            = r_done;
   assign bus.timeout_o         = r_timeout;
   assign bus.last_broken_o     = r_snap_lb;
endmodule
`default_nettype wire

// File: tb/tb_egg_run_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_egg_run_sequencer
//  Purpose  : Scoreboard bench for egg_run_sequencer with a small CPU model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_egg_run_sequencer;
   localparam int K_NOW   = 0;
   localparam int K_DONE  = 1;
   localparam int K_TO    = 2;
   localparam int K_PAGE  = 3;
   localparam int K_RSTF  = 4;
   localparam int K_BUSYR = 5;

   localparam int F_CRST = 0;
   localparam int F_BUSY = 1;
   localparam int F_DONE = 2;
   localparam int F_TO   = 3;
   localparam int F_LB   = 4;
   localparam int F_PAGE = 5;
   localparam int F_DISP = 6;
   localparam int F_INF  = 7;
   localparam int F_INR  = 8;

   typedef struct {
      string            name;
      int               kind;
      int               ecyc;
      logic [8:0]       en;
      logic [8:0][31:0] exp;
   } rec_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   mode = 0;
   int   k = 0;
   rec_t sbq[$];
   rec_t cur;

   logic       p_done, p_to, p_crst, p_busy;
   logic [1:0] p_page;
   int         waitc;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   egg_run_sequencer_if bus();

   egg_run_sequencer #(
      .RST_CYCLES(4), .HALT_CYCLES(8), .MAX_CYCLES(100), .PAGE_CYCLES(5)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   function automatic string fname(input int i);
      case (i)
         F_CRST:  return "cpu_rst_o";
         F_BUSY:  return "busy_o";
         F_DONE:  return "done_o";
         F_TO:    return "timeout_o";
         F_LB:    return "last_broken_o";
         F_PAGE:  return "page_o";
         F_DISP:  return "disp_data_o";
         F_INF:   return "init_floors_o";
         default: return "init_resistance_o";
      endcase
   endfunction

   task automatic rnew(input string n, input int kd, input int ec);
      cur.name = n;
      cur.kind = kd;
      cur.ecyc = ec;
      cur.en   = '0;
      cur.exp  = '0;
   endtask

   task automatic rf(input int i, input logic [31:0] v);
      cur.en[i]  = 1'b1;
      cur.exp[i] = v;
   endtask

   task automatic rpush();
      sbq.push_back(cur);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // CPU model: PC steps every 2 cycles for 20 cycles then freezes (mode 0),
   // or changes every cycle forever (mode 1)
   initial begin
      forever begin
         @(negedge clk);
         if (bus.cpu_rst_o === 1'b1) begin
            k = 0;
            bus.cpu_pc_i = 32'd0; bus.attempt_count_i = 32'd0; bus.broken_count_i = 32'd0;
            bus.cost_f1_i = 32'd0; bus.cost_f2_i = 32'd0; bus.last_broken_i = 1'b0;
         end else begin
            if (mode == 0) begin
               if (k < 20) begin
                  bus.cpu_pc_i = 32'(k / 2); bus.attempt_count_i = 32'(k); bus.broken_count_i = 32'd0;
                  bus.cost_f1_i = 32'd0; bus.cost_f2_i = 32'd0; bus.last_broken_i = 1'b0;
               end else begin
                  bus.cpu_pc_i = 32'd10; bus.attempt_count_i = 32'd14; bus.broken_count_i = 32'd2;
                  bus.cost_f1_i = 32'd3; bus.cost_f2_i = 32'd9; bus.last_broken_i = 1'b1;
               end
            end else begin
               bus.cpu_pc_i = 32'(k); bus.attempt_count_i = 32'(k); bus.broken_count_i = 32'd5;
               bus.cost_f1_i = 32'd0; bus.cost_f2_i = 32'd0; bus.last_broken_i = 1'b1;
            end
            k = k + 1;
         end
      end
   end

   // Monitor: pops the head record when its trigger event appears and compares
   initial begin
      logic [8:0][31:0] act;
      rec_t h;
      bit fire;
      p_done = 1'b0; p_to = 1'b0; p_crst = 1'b1; p_busy = 1'b0; p_page = 2'd0; waitc = 0;
      forever begin
         @(posedge clk);
         #1;
         act[F_CRST] = 32'(bus.cpu_rst_o);
         act[F_BUSY] = 32'(bus.busy_o);
         act[F_DONE] = 32'(bus.done_o);
         act[F_TO]   = 32'(bus.timeout_o);
         act[F_LB]   = 32'(bus.last_broken_o);
         act[F_PAGE] = 32'(bus.page_o);
         act[F_DISP] = bus.disp_data_o;
         act[F_INF]  = bus.init_floors_o;
         act[F_INR]  = bus.init_resistance_o;
         if (sbq.size() > 0) begin
            h = sbq[0];
            case (h.kind)
               K_DONE:  fire = (bus.done_o === 1'b1) && !p_done;
               K_TO:    fire = (bus.timeout_o === 1'b1) && !p_to;
               K_PAGE:  fire = (bus.page_o !== p_page);
               K_RSTF:  fire = (bus.cpu_rst_o === 1'b0) && p_crst;
               K_BUSYR: fire = (bus.busy_o === 1'b1) && !p_busy;
               default: fire = 1'b1;
            endcase
            if (fire) begin
               void'(sbq.pop_front());
               waitc = 0;
               if (h.ecyc >= 0) begin
                  checks++;
                  if (cyc != h.ecyc) begin
                     errors++;
                     $display("FAIL %s cycle: got %0d expected %0d", h.name, cyc, h.ecyc);
                  end
               end
               for (int i = 0; i < 9; i++) begin
                  if (h.en[i]) begin
                     checks++;
                     if (act[i] !== h.exp[i]) begin
                        errors++;
                        $display("FAIL %s %s: got %h expected %h", h.name, fname(i), act[i], h.exp[i]);
                     end
                  end
               end
            end else begin
               waitc++;
               if (waitc > 400) begin
                  checks++;
                  errors++;
                  $display("FAIL %s event: not seen within 400 cycles", h.name);
                  void'(sbq.pop_front());
                  waitc = 0;
               end
            end
         end
         p_done = bus.done_o; p_to = bus.timeout_o; p_crst = bus.cpu_rst_o;
         p_busy = bus.busy_o; p_page = bus.page_o;
      end
   end

   // Directed stimulus
   initial begin
      int s;
      int guard;
      rst = 1'b1;
      bus.in_data_i = 16'd0; bus.load_floors_i = 1'b0; bus.load_resist_i = 1'b0; bus.start_i = 1'b0;
      tick(2);
      rnew("reset", K_NOW, -1);
      rf(F_CRST, 1); rf(F_BUSY, 0); rf(F_DONE, 0); rf(F_TO, 0); rf(F_LB, 0);
      rf(F_PAGE, 0); rf(F_DISP, 0); rf(F_INF, 0); rf(F_INR, 0);
      rpush();
      tick(1);
      rst = 1'b0;

      // Parameter loads in IDLE, then both loads together
      bus.in_data_i = 16'd100; bus.load_floors_i = 1'b1;
      tick(1);
      bus.in_data_i = 16'd2; bus.load_floors_i = 1'b0; bus.load_resist_i = 1'b1;
      tick(1);
      bus.load_resist_i = 1'b0;
      rnew("load", K_NOW, -1);
      rf(F_INF, 100); rf(F_INR, 2); rf(F_DISP, 32'h0064_0002); rf(F_CRST, 1); rf(F_BUSY, 0);
      rpush();
      tick(2);
      bus.in_data_i = 16'd7; bus.load_floors_i = 1'b1; bus.load_resist_i = 1'b1;
      tick(1);
      bus.load_floors_i = 1'b0; bus.load_resist_i = 1'b0;
      rnew("load_both", K_NOW, -1);
      rf(F_INF, 7); rf(F_INR, 2); rf(F_DISP, 32'h0007_0002);
      rpush();
      tick(2);

      // Halting run with start held high throughout
      mode = 0;
      bus.start_i = 1'b1;
      s = cyc + 1;
      rnew("release", K_RSTF, s + 4);
      rf(F_BUSY, 1); rf(F_DONE, 0);
      rpush();
      tick(10);
      bus.in_data_i = 16'd55; bus.load_floors_i = 1'b1;
      tick(1);
      bus.load_floors_i = 1'b0;
      rnew("run_load", K_NOW, -1);
      rf(F_INF, 7); rf(F_INR, 2); rf(F_BUSY, 1); rf(F_CRST, 0);
      rpush();
      rnew("done", K_DONE, s + 33);
      rf(F_DISP, 32'h000E_0002); rf(F_LB, 1); rf(F_PAGE, 0); rf(F_BUSY, 0); rf(F_CRST, 0); rf(F_INF, 7);
      rpush();
      rnew("page1", K_PAGE, s + 38); rf(F_PAGE, 1); rf(F_DISP, 32'd3); rpush();
      rnew("page2", K_PAGE, s + 43); rf(F_PAGE, 2); rf(F_DISP, 32'd9); rpush();
      rnew("page3", K_PAGE, s + 48); rf(F_PAGE, 3); rf(F_DISP, 32'h0007_0002); rpush();
      rnew("page0", K_PAGE, s + 53); rf(F_PAGE, 0); rf(F_DISP, 32'h000E_0002); rpush();
      guard = 0;
      while (cyc < s + 58 && guard < 200) begin tick(1); guard++; end
      rnew("held", K_NOW, -1);
      rf(F_DONE, 1); rf(F_BUSY, 0); rf(F_CRST, 0);
      rpush();
      tick(2);

      // Fresh start edge from DONE
      bus.start_i = 1'b0;
      tick(1);
      bus.start_i = 1'b1;
      s = cyc + 1;
      rnew("restart", K_BUSYR, s);
      rf(F_BUSY, 1); rf(F_DONE, 0); rf(F_CRST, 1); rf(F_TO, 0);
      rpush();
      tick(9);

      // Reset in the middle of RUN
      rst = 1'b1;
      rnew("midrst", K_NOW, -1);
      rf(F_CRST, 1); rf(F_BUSY, 0); rf(F_DONE, 0); rf(F_TO, 0); rf(F_LB, 0);
      rf(F_PAGE, 0); rf(F_DISP, 0); rf(F_INF, 0); rf(F_INR, 0);
      rpush();
      tick(1);
      rst = 1'b0; bus.start_i = 1'b0;

      // Timeout run
      bus.in_data_i = 16'd3; bus.load_floors_i = 1'b1;
      tick(1);
      bus.in_data_i = 16'd4; bus.load_floors_i = 1'b0; bus.load_resist_i = 1'b1;
      tick(1);
      bus.load_resist_i = 1'b0;
      mode = 1;
      tick(1);
      bus.start_i = 1'b1;
      s = cyc + 1;
      rnew("timeout", K_TO, s + 104);
      rf(F_TO, 1); rf(F_CRST, 1); rf(F_BUSY, 0); rf(F_DONE, 0); rf(F_DISP, 32'h0063_0005);
      rf(F_PAGE, 0); rf(F_LB, 1); rf(F_INF, 3); rf(F_INR, 4);
      rpush();
      guard = 0;
      while (cyc < s + 110 && guard < 400) begin tick(1); guard++; end
      rnew("to_hold", K_NOW, -1);
      rf(F_TO, 1); rf(F_DISP, 32'h0063_0005); rf(F_CRST, 1); rf(F_PAGE, 0);
      rpush();
      tick(1);
      bus.start_i = 1'b0;

      guard = 0;
      while (sbq.size() > 0 && guard < 1000) begin tick(1); guard++; end
      if (sbq.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d records pending expected 0", sbq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/egg_run_sequencer.md
Name: egg_run_sequencer

Overview:
- Run controller for the egg-drop CPU experiment.
- Latches floor and resistance parameters from the switch bus.
- Holds the CPU core in reset, releases it, detects halt by a PC that stays stable, flags a timeout, and snapshots the result counters.
- After a run, rotates the result pages onto the 32-bit seven-segment display word. Runs on the undivided board clock, alongside the CPU wrapper and display driver.

Parameters:
- RST_CYCLES, 16, cycles cpu_rst_o is held high after a start.
- HALT_CYCLES, 64, consecutive cycles of unchanged PC that declare a halt. Must exceed the CPU clock-divider period.
- MAX_CYCLES, 1000000, run-length limit before timeout.
- PAGE_CYCLES, 50000000, cycles each display page is shown in DONE.

Ports:
- clk_i  in  1  board clock.
- rst_i  in  1  synchronous active-high reset.
- in_data_i  in  16  switch data.
- load_floors_i  in  1  latch in_data_i as the floor count.
- load_resist_i  in  1  latch in_data_i as the resistance.
- start_i  in  1  start request, rising-edge detected.
- cpu_pc_i  in  32  CPU program counter.
- attempt_count_i  in  32  CPU attempt counter.
- broken_count_i  in  32  CPU broken counter.
- last_broken_i  in  1  CPU last-broken flag.
- cost_f1_i  in  32  CPU cost f1.
- cost_f2_i  in  32  CPU cost f2.
- cpu_rst_o  out  1  reset to the CPU wrapper.
- init_floors_o  out  32  {16'b0, floors_r}.
- init_resistance_o  out  32  {16'b0, resist_r}.
- disp_data_o  out  32  display word.
- page_o  out  2  current page index.
- busy_o  out  1  high in RESET_CPU and RUN.
- done_o  out  1  high in DONE.
- timeout_o  out  1  high in TIMEOUT.
- last_broken_o  out  1  snapshot of last_broken_i.

Behaviour:
- Reset (rst_i sampled high on a clk_i edge), from any state including mid-run:
  - state goes to IDLE.
  - floors_r = resist_r = 0, all snapshots = 0, page_o = 0.
  - cpu_rst_o = 1; busy_o, done_o, timeout_o, last_broken_o = 0.
- Parameter load:
  - Accepted only in IDLE, DONE and TIMEOUT. Ignored in RESET_CPU and RUN.
  - If load_floors_i and load_resist_i are high together, only floors_r loads.
  - Takes effect on the next edge.
- Start: start_r holds the previous start_i. A start event is start_i & ~start_r, accepted in IDLE, DONE or TIMEOUT; events in other states are dropped.
- States:
  - IDLE:
    - cpu_rst_o = 1.
    - disp_data_o = {floors_r, resist_r}.
    - Start event -> RESET_CPU, cnt = 0.
  - RESET_CPU:
    - cpu_rst_o = 1.
    - cnt increments. At cnt == RST_CYCLES-1 -> RUN, with cnt = 0, stable = 0, pc_prev = cpu_pc_i.
  - RUN:
    - cpu_rst_o = 0.
    - Each cycle, cnt increments. If cpu_pc_i == pc_prev then stable increments, else stable = 0 and pc_prev = cpu_pc_i.
    - disp_data_o = live {attempt_count_i[15:0], broken_count_i[15:0]}.
    - stable == HALT_CYCLES-1 with PC still equal -> DONE. On that edge, snapshot attempt, broken, cost_f1, cost_f2 and last_broken; page_o = 0, page timer = 0.
    - Else cnt == MAX_CYCLES-1 -> TIMEOUT. Snapshot the same values.
    - Halt has priority if both conditions hit on the same cycle.
  - DONE:
    - cpu_rst_o = 0, so the CPU stays halted and its state is preserved.
    - Page timer counts. At PAGE_CYCLES-1 the timer clears and page_o increments, wrapping 3 -> 0.
    - Page words:
      - page 0: {attempt[15:0], broken[15:0]}.
      - page 1: cost_f1.
      - page 2: cost_f2.
      - page 3: {floors_r, resist_r}.
    - Start event -> RESET_CPU (re-run).
  - TIMEOUT:
    - cpu_rst_o = 1.
    - disp_data_o = snapshot page 0; page_o frozen at 0.
    - Start event -> RESET_CPU.
- Output timing: all outputs are registered or decoded from registered state. No combinational input-to-output path except init_* from the registers.
- Counters:
  - cnt is 32 bits and cannot wrap before MAX_CYCLES.
  - stable and the page timer are sized with $clog2 of their parameter.
  - Snapshots are full 32-bit copies, no truncation. Truncation happens only in the display packing.

Test Plan (RST_CYCLES=4, HALT_CYCLES=8, MAX_CYCLES=100, PAGE_CYCLES=5):
1. in_data_i=16'd100 with load_floors_i, then 16'd2 with load_resist_i. -> init_floors_o=32'd100, init_resistance_o=32'd2, disp_data_o=32'h0064_0002 in IDLE. Then pulse both loads with 16'd7 -> floors_r=7, resist_r unchanged at 2.
2. Start pulse; the model CPU increments PC every 2 cycles for 20 cycles, then freezes with attempt=14, broken=2, f1=3, f2=9, last_broken=1.
   - cpu_rst_o is high exactly 4 cycles after the start edge.
   - done_o rises 8 cycles after the PC freezes; last_broken_o=1.
   - page_o cycles 0,1,2,3,0 every 5 cycles, showing 32'h000E_0002, 3, 9, {floors,resist}.
3. The PC never stops changing. -> timeout_o rises after 100 RUN cycles, cpu_rst_o=1, disp_data_o holds the snapshot page 0.
4. Hold start_i high continuously from IDLE. -> exactly one run; no restart in DONE until start_i falls and rises again. A start pulse in DONE -> RESET_CPU, done_o=0, busy_o=1.
5. Assert rst_i in the middle of RUN. -> next edge: IDLE, cpu_rst_o=1, floors_r=0, snapshots cleared, busy_o=0.
6. Pulse load_floors_i during RUN with in_data_i=16'd55. -> floors_r unchanged; init_floors_o stable for the whole run.
